// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command-master state encoding.
// Both the command master and the axi4_lite_gpu slave import this package.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } master_state_e;

endpackage

// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite control bus bundle (AR/R/AW/W/B channels) with master and slave views.
interface axi4_lite_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns one-beat register commands into
// AXI4-Lite reads/writes, with independent AW/W tracking and a per-transaction timeout.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES    = 256
) (
  input  logic                         m_axi_ctrl_aclk,
  input  logic                         m_axi_ctrl_aresetn,

  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]    cmd_wdata,

  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         rsp_timeout,

  axi4_lite_cmd_master_if.master       m_axi_ctrl
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Every output is a field of this register, so nothing reaches a port combinationally.
  typedef struct packed {
    master_state_e               state;
    logic [CNT_W-1:0]            cnt;
    logic [AXI_ADDRESS_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic                        write;
    logic                        cmd_ready;
    logic                        arvalid;
    logic                        rready;
    logic                        awvalid;
    logic                        wvalid;
    logic                        bready;
    logic                        rsp_valid;
    logic                        rsp_write;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata;
    axi_resp_e                   rsp_resp;
    logic                        rsp_timeout;
  } regs_t;

  regs_t r_q, r_d;
  logic  timeout_hit;
  logic  abort;

  assign timeout_hit = (r_q.cnt == CNT_LAST);

  always_comb begin
    // NOTE: defaulting every written variable first keeps this block free of latches.
    r_d   = r_q;
    abort = 1'b0;

    case (r_q.state)
      ST_IDLE: begin
        r_d.cmd_ready = 1'b1;
        if (cmd_valid && r_q.cmd_ready) begin
          r_d.cmd_ready = 1'b0;
          r_d.addr      = cmd_addr;
          r_d.wdata     = cmd_wdata;
          r_d.write     = cmd_write;
          r_d.cnt       = '0;
          if (cmd_write) begin
            r_d.state   = ST_WR_REQ;
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
          end else begin
            r_d.state   = ST_RD_REQ;
            r_d.arvalid = 1'b1;
          end
        end
      end

      ST_WR_REQ: begin
        r_d.cnt = r_q.cnt + CNT_W'(1);
        // A low valid in this state means that channel has already handshaken.
        if (r_q.awvalid && m_axi_ctrl.awready) r_d.awvalid = 1'b0;
        if (r_q.wvalid  && m_axi_ctrl.wready)  r_d.wvalid  = 1'b0;
        if (timeout_hit) begin
          abort = 1'b1;
        end else if (!r_d.awvalid && !r_d.wvalid) begin
          r_d.state  = ST_WR_RESP;
          r_d.bready = 1'b1;
        end
      end

      ST_WR_RESP: begin
        r_d.cnt = r_q.cnt + CNT_W'(1);
        // A beat landing on the timeout cycle is still a valid completion.
        if (m_axi_ctrl.bvalid) begin
          r_d.state       = ST_RSP;
          r_d.bready      = 1'b0;
          r_d.rsp_valid   = 1'b1;
          r_d.rsp_write   = 1'b1;
          r_d.rsp_rdata   = '0;
          r_d.rsp_resp    = axi_resp_e'(m_axi_ctrl.bresp);
          r_d.rsp_timeout = 1'b0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      ST_RD_REQ: begin
        r_d.cnt = r_q.cnt + CNT_W'(1);
        if (timeout_hit) begin
          abort = 1'b1;
        end else if (m_axi_ctrl.arready) begin
          r_d.state   = ST_RD_DATA;
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
        end
      end

      ST_RD_DATA: begin
        r_d.cnt = r_q.cnt + CNT_W'(1);
        if (m_axi_ctrl.rvalid) begin
          r_d.state       = ST_RSP;
          r_d.rready      = 1'b0;
          r_d.rsp_valid   = 1'b1;
          r_d.rsp_write   = 1'b0;
          r_d.rsp_rdata   = m_axi_ctrl.rdata;
          r_d.rsp_resp    = axi_resp_e'(m_axi_ctrl.rresp);
          r_d.rsp_timeout = 1'b0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          r_d.state     = ST_IDLE;
          r_d.rsp_valid = 1'b0;
          r_d.cmd_ready = 1'b1;
        end
      end

      default: r_d.state = ST_IDLE;
    endcase

    if (abort) begin
      r_d.state       = ST_RSP;
      r_d.arvalid     = 1'b0;
      r_d.rready      = 1'b0;
      r_d.awvalid     = 1'b0;
      r_d.wvalid      = 1'b0;
      r_d.bready      = 1'b0;
      r_d.rsp_valid   = 1'b1;
      r_d.rsp_write   = r_q.write;
      r_d.rsp_rdata   = '0;
      r_d.rsp_resp    = RESP_SLVERR;
      r_d.rsp_timeout = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge m_axi_ctrl_aclk or negedge m_axi_ctrl_aresetn) begin
    if (!m_axi_ctrl_aresetn) r_q <= '0;
    else                     r_q <= r_d;
  end

  assign cmd_ready   = r_q.cmd_ready;
  assign rsp_valid   = r_q.rsp_valid;
  assign rsp_write   = r_q.rsp_write;
  assign rsp_rdata   = r_q.rsp_rdata;
  assign rsp_resp    = r_q.rsp_resp;
  assign rsp_timeout = r_q.rsp_timeout;

  assign m_axi_ctrl.araddr  = r_q.addr;
  assign m_axi_ctrl.arvalid = r_q.arvalid;
  assign m_axi_ctrl.rready  = r_q.rready;
  assign m_axi_ctrl.awaddr  = r_q.addr;
  assign m_axi_ctrl.awvalid = r_q.awvalid;
  assign m_axi_ctrl.wdata   = r_q.wdata;
  assign m_axi_ctrl.wvalid  = r_q.wvalid;
  assign m_axi_ctrl.bready  = r_q.bready;

endmodule
